// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the PC, reads imem by req/ack and presents the decoded word until retired.
// Latency: instruction valid the cycle after the acking edge; 2 cycles retire-to-valid with zero-wait memory.
// Backpressure: holds VALID until retire; holds imemReq/imemAddr stable in REQ until imemAck.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    input  logic        retire,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        instrValid,
    output logic        misaligned,
    output logic [31:0] retireCount
);

    typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        imemReq    = 1'b0;
        instrValid = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imemReq = 1'b1;
                if (imemAck) state_nxt = VALID;
            end
            VALID: begin
                instrValid = 1'b1;
                if (retire) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Acks and retires are only honoured in their own state; anything else is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            misaligned  <= 1'b0;
            retireCount <= 32'd0;
        end else begin
            if (state == REQ && imemAck) begin
                instr <= imemRdata;
            end
            if (state == VALID && retire) begin
                pc          <= pcSrc ? {pcTarget[31:2], 2'b00} : pcPlus4;
                instr       <= NOP_INSTR;
                retireCount <= retireCount + 32'd1;
                if (pcSrc && (pcTarget[1:0] != 2'b00)) misaligned <= 1'b1;
            end
        end
    end

    assign imemAddr = pc;
    assign pcPlus4  = pc + 32'd4;
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];

endmodule
